// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch: IDLE/RUN/PAUSE control, programmable tick prescaler
// and a cascaded decade-digit chain with a sticky wrap flag.
module bcd_stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_clr,
  output logic [15:0] o_bcd,
  output logic        o_running,
  output logic        o_tick,
  output logic        o_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  state_t      state;
  logic [15:0] presc;
  logic [15:0] bcd_inc;
  logic        carry;
  logic        wrap;

  assign o_tick = (state == RUN) && (presc == LAST);

  // Digit k advances only while every lower digit is 9; carry out of d3 is the wrap.
  always_comb begin
    bcd_inc = o_bcd;
    carry   = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      if (carry)
        bcd_inc[4*k +: 4] = (o_bcd[4*k +: 4] == 4'd9) ? 4'd0 : o_bcd[4*k +: 4] + 4'd1;
      carry = carry && (o_bcd[4*k +: 4] == 4'd9);
    end
    wrap = carry;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      o_bcd     <= '0;
      o_running <= 1'b0;
      o_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_clr && i_start) begin
            state     <= RUN;
            o_running <= 1'b1;
          end
        end
        RUN, PAUSE: begin
          if (i_clr) begin
            state     <= IDLE;
            presc     <= '0;
            o_bcd     <= '0;
            o_running <= 1'b0;
            o_ovf     <= 1'b0;
          end else if (i_stop) begin
            state     <= PAUSE;
            o_running <= 1'b0;
          end else if (state == RUN) begin
            if (o_tick) begin
              presc <= '0;
              o_bcd <= bcd_inc;
              if (wrap)
                o_ovf <= 1'b1;
            end else begin
              presc <= presc + 16'd1;
            end
          end else if (i_start) begin
            // Resume without advancing: the held prescaler value carries over.
            state     <= RUN;
            o_running <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          o_running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: a per-cycle vector table through a scoreboard
// queue on a TICK_DIV=4 instance, then multi-cycle sequences on 4 and 1.
module tb_bcd_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst4_n, rst1_n;
  logic        start4, stop4, clr4, start1, stop1, clr1;
  logic [15:0] bcd4, bcd1;
  logic        run4, run1, tick4, tick1, ovf4, ovf1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .i_rst_n(rst4_n), .i_start(start4), .i_stop(stop4), .i_clr(clr4),
    .o_bcd(bcd4), .o_running(run4), .o_tick(tick4), .o_ovf(ovf4)
  );

  bcd_stopwatch_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .i_rst_n(rst1_n), .i_start(start1), .i_stop(stop1), .i_clr(clr1),
    .o_bcd(bcd1), .o_running(run1), .o_tick(tick1), .o_ovf(ovf1)
  );

  typedef struct {
    logic        s, p, c;
    logic [15:0] bcd;
    logic        run, tick, ovf;
  } vec_t;

  vec_t vecs[17];
  vec_t sb[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one edge's requests on the selected instance; outputs sampled 1ns after the edge.
  task automatic step(input bit sel1, input logic s, input logic p, input logic c);
    @(negedge clk);
    start4 = sel1 ? 1'b0 : s; stop4 = sel1 ? 1'b0 : p; clr4 = sel1 ? 1'b0 : c;
    start1 = sel1 ? s : 1'b0; stop1 = sel1 ? p : 1'b0; clr1 = sel1 ? c : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit sel1, input int n);
    for (int i = 0; i < n; i++) step(sel1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1,0,0, 16'h0000, 1,0,0};
    vecs[1]  = '{0,0,0, 16'h0000, 1,0,0};
    vecs[2]  = '{0,0,0, 16'h0000, 1,0,0};
    vecs[3]  = '{0,0,0, 16'h0000, 1,1,0};
    vecs[4]  = '{0,0,0, 16'h0001, 1,0,0};
    vecs[5]  = '{0,0,0, 16'h0001, 1,0,0};
    vecs[6]  = '{0,0,0, 16'h0001, 1,0,0};
    vecs[7]  = '{0,0,0, 16'h0001, 1,1,0};
    vecs[8]  = '{0,1,0, 16'h0001, 0,0,0};   // stop on the tick edge: no increment
    vecs[9]  = '{0,0,0, 16'h0001, 0,0,0};
    vecs[10] = '{1,0,0, 16'h0001, 1,1,0};   // resume with prescaler at its last value
    vecs[11] = '{0,0,1, 16'h0000, 0,0,0};   // clear on the tick edge
    vecs[12] = '{1,0,0, 16'h0000, 1,0,0};
    vecs[13] = '{0,0,0, 16'h0000, 1,0,0};
    vecs[14] = '{0,0,0, 16'h0000, 1,0,0};
    vecs[15] = '{0,0,0, 16'h0000, 1,1,0};
    vecs[16] = '{0,0,0, 16'h0001, 1,0,0};

    {start4, stop4, clr4, start1, stop1, clr1} = '0;
    rst4_n = 1'b0; rst1_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd4", bcd4, 16'h0000);
    check("rst_run4", {15'd0, run4}, 16'd0);
    check("rst_tick4", {15'd0, tick4}, 16'd0);
    check("rst_ovf4", {15'd0, ovf4}, 16'd0);
    check("rst_bcd1", bcd1, 16'h0000);
    check("rst_tick1", {15'd0, tick1}, 16'd0);
    @(negedge clk);
    rst4_n = 1'b1; rst1_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      sb.push_back(vecs[i]);
      step(1'b0, vecs[i].s, vecs[i].p, vecs[i].c);
      begin
        vec_t e;
        e = sb.pop_front();
        check($sformatf("vec%0d_bcd", i), bcd4, e.bcd);
        check($sformatf("vec%0d_run", i), {15'd0, run4}, {15'd0, e.run});
        check($sformatf("vec%0d_tick", i), {15'd0, tick4}, {15'd0, e.tick});
        check($sformatf("vec%0d_ovf", i), {15'd0, ovf4}, {15'd0, e.ovf});
      end
    end

    // Two-digit carry: 0010 after 40 edges from start.
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle(0, 39);
    check("carry_0009", bcd4, 16'h0009);
    idle(0, 1);
    check("carry_0010", bcd4, 16'h0010);

    // Pause two cycles past 0003, hold 10 cycles, resume.
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle(0, 14);
    check("pre_pause", bcd4, 16'h0003);
    step(0, 0, 1, 0);
    check("pause_run", {15'd0, run4}, 16'd0);
    idle(0, 10);
    check("paused_hold", bcd4, 16'h0003);
    step(0, 1, 0, 0);
    check("resume_run", {15'd0, run4}, 16'd1);
    check("resume_bcd", bcd4, 16'h0003);
    idle(0, 1);
    check("resume_plus1", bcd4, 16'h0003);
    idle(0, 1);
    check("resume_plus2", bcd4, 16'h0004);

    // Asynchronous reset mid-run at 0129.
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle(0, 516);
    check("run_0129", bcd4, 16'h0129);
    @(negedge clk);
    rst4_n = 1'b0;
    #1;
    check("async_rst_bcd", bcd4, 16'h0000);
    check("async_rst_run", {15'd0, run4}, 16'd0);
    @(negedge clk);
    rst4_n = 1'b1;
    idle(0, 8);
    check("post_rst_bcd", bcd4, 16'h0000);
    check("post_rst_run", {15'd0, run4}, 16'd0);

    // Clear from PAUSE, then a fresh start counts from zero.
    step(0, 1, 0, 0);
    idle(0, 6);
    step(0, 0, 1, 0);
    check("pause_bcd", bcd4, 16'h0001);
    step(0, 0, 0, 1);
    check("pclr_bcd", bcd4, 16'h0000);
    check("pclr_run", {15'd0, run4}, 16'd0);
    check("pclr_ovf", {15'd0, ovf4}, 16'd0);
    step(0, 1, 0, 0);
    idle(0, 3);
    check("restart_3", bcd4, 16'h0000);
    check("restart_tick", {15'd0, tick4}, 16'd1);
    idle(0, 1);
    check("restart_4", bcd4, 16'h0001);

    // TICK_DIV=1: full range and overflow.
    step(1, 1, 0, 0);
    check("d1_tick", {15'd0, tick1}, 16'd1);
    idle(1, 9999);
    check("d1_9999", bcd1, 16'h9999);
    check("d1_ovf_pre", {15'd0, ovf1}, 16'd0);
    idle(1, 1);
    check("d1_wrap", bcd1, 16'h0000);
    check("d1_ovf", {15'd0, ovf1}, 16'd1);
    check("d1_run", {15'd0, run1}, 16'd1);
    idle(1, 42);
    check("d1_0042", bcd1, 16'h0042);
    check("d1_ovf_sticky", {15'd0, ovf1}, 16'd1);
    step(1, 1, 1, 1);
    check("d1_all_bcd", bcd1, 16'h0000);
    check("d1_all_run", {15'd0, run1}, 16'd0);
    check("d1_all_ovf", {15'd0, ovf1}, 16'd0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    check("d1_stopstart_run", {15'd0, run1}, 16'd0);
    check("d1_stopstart_bcd", bcd1, 16'h0000);
    check("d1_paused_tick", {15'd0, tick1}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
